// File: rtl/vec_store_seq.sv
// Drains up to ELEMS_PER_REG*LMUL elements from vector registers into packed 32-bit store words.
// Latency: two cycles per element (RD, CAP) plus one OUT cycle per word when st_ready is held high.
// Backpressure: OUT holds st_valid/st_data/st_strb stable until st_ready; no reads are issued while stalled.
module vec_store_seq #(
    parameter int ELEMS_PER_REG = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    input  logic [4:0]  vs3,
    input  logic [2:0]  lmul,
    input  logic [2:0]  vsew,
    input  logic [31:0] vl,
    output logic        busy,
    output logic        rf_re,
    output logic [7:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        st_valid,
    output logic [31:0] st_data,
    output logic [3:0]  st_strb,
    input  logic        st_ready,
    output logic        w_done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        OUT  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [4:0]  vs3_q;
    logic [1:0]  vsew_q;
    logic [31:0] n_q;
    logic [31:0] e_q;
    logic [31:0] word_q;
    logic [3:0]  strb_q;
    logic        err_q;

    logic        cfg_ok;
    logic [31:0] max_elems;
    logic [31:0] n_calc;
    logic        word_full;
    logic        last_elem;
    logic [4:0]  vreg_sel;
    logic [2:0]  slot_sel;

    // Decode the start request: legality of LMUL/SEW/alignment and the clamped element count
    always_comb begin
        cfg_ok = 1'b0;
        if (!lmul[2] && (vsew == 3'b000 || vsew == 3'b001 || vsew == 3'b010)) begin
            case (lmul[1:0])
                2'b00:   cfg_ok = 1'b1;
                2'b01:   cfg_ok = (vs3[0] == 1'b0);
                2'b10:   cfg_ok = (vs3[1:0] == 2'b00);
                default: cfg_ok = (vs3[2:0] == 3'b000);
            endcase
        end
        max_elems = 32'(ELEMS_PER_REG) << lmul[1:0];
        n_calc    = (vl < max_elems) ? vl : max_elems;
    end

    // A word is full once the top lane for the current element width has been written
    always_comb begin
        case (vsew_q)
            2'b00:   word_full = (e_q[1:0] == 2'b11);
            2'b01:   word_full = e_q[0];
            default: word_full = 1'b1;
        endcase
        last_elem = ((e_q + 32'd1) == n_q);
        vreg_sel  = vs3_q + 5'(e_q / 32'(ELEMS_PER_REG));
        slot_sel  = 3'(e_q % 32'(ELEMS_PER_REG));
    end

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        rf_re     = 1'b0;
        rf_addr   = 8'd0;
        st_valid  = 1'b0;
        w_done    = 1'b0;
        case (state)
            IDLE: begin
                if (start && cfg_ok) state_nxt = (n_calc == 32'd0) ? DONE : RD;
            end
            RD: begin
                busy      = 1'b1;
                rf_re     = 1'b1;
                rf_addr   = {vreg_sel, slot_sel};
                state_nxt = CAP;
            end
            CAP: begin
                busy      = 1'b1;
                state_nxt = (word_full || last_elem) ? OUT : RD;
            end
            OUT: begin
                busy     = 1'b1;
                st_valid = 1'b1;
                if (st_ready) state_nxt = (e_q < n_q) ? RD : DONE;
            end
            DONE: begin
                w_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latching, element counter and store-word assembly
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vs3_q  <= 5'd0;
            vsew_q <= 2'd0;
            n_q    <= 32'd0;
            e_q    <= 32'd0;
            word_q <= 32'd0;
            strb_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && start && !cfg_ok;
            case (state)
                IDLE: begin
                    if (start && cfg_ok) begin
                        vs3_q  <= vs3;
                        vsew_q <= vsew[1:0];
                        n_q    <= n_calc;
                        e_q    <= 32'd0;
                        word_q <= 32'd0;
                        strb_q <= 4'd0;
                    end
                end
                CAP: begin
                    case (vsew_q)
                        2'b00: begin
                            word_q[{e_q[1:0], 3'b000} +: 8] <= rf_rdata[7:0];
                            strb_q[e_q[1:0]]                <= 1'b1;
                        end
                        2'b01: begin
                            word_q[{e_q[0], 4'b0000} +: 16] <= rf_rdata[15:0];
                            strb_q[{e_q[0], 1'b0} +: 2]     <= 2'b11;
                        end
                        default: begin
                            word_q <= rf_rdata;
                            strb_q <= 4'hF;
                        end
                    endcase
                    e_q <= e_q + 32'd1;
                end
                OUT: begin
                    if (st_ready) begin
                        word_q <= 32'd0;
                        strb_q <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign st_data = word_q;
    assign st_strb = strb_q;
    assign err     = err_q;

endmodule

// File: tb/tb_vec_store_seq.sv
// Randomised and directed bench for vec_store_seq with a queue-based reference model.
// Model predicts the read-address stream and store words from the element rules directly.
// Store backpressure is exercised with held-low and random st_ready.
module tb_vec_store_seq;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [4:0]  vs3;
    logic [2:0]  lmul;
    logic [2:0]  vsew;
    logic [31:0] vl;
    logic        busy;
    logic        rf_re;
    logic [7:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        st_valid;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic        st_ready;
    logic        w_done;
    logic        err;

    vec_store_seq #(.ELEMS_PER_REG(8)) dut (
        .clk(clk), .nrst(nrst), .start(start), .vs3(vs3), .lmul(lmul), .vsew(vsew), .vl(vl),
        .busy(busy), .rf_re(rf_re), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .st_valid(st_valid), .st_data(st_data), .st_strb(st_strb), .st_ready(st_ready),
        .w_done(w_done), .err(err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int data_mode = 0;
    logic [7:0] salt = 8'h00;
    int rdy_mode = 0;

    logic [7:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_strb[$];

    int busy_cnt = 0, wd_cnt = 0, err_cnt = 0, re_cnt = 0;
    bit hold = 0;
    logic [31:0] hold_d;
    logic [3:0]  hold_s;
    logic        rf_re_s = 1'b0;
    logic [7:0]  rd_addr_s = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic logic [31:0] rdata_fn(input logic [7:0] a);
        case (data_mode)
            1:       return {29'd0, a[2:0]} + 32'd1;
            2:       return 32'hA0 + {29'd0, a[2:0]};
            default: return {a, ~a, a + salt, a ^ salt};
        endcase
    endfunction

    // Reference: address stream and packed words straight from the element rules
    task automatic build_model(input logic [4:0] v, input logic [2:0] lm, input logic [2:0] sw,
                               input logic [31:0] l, output bit legal);
        int unsigned maxe, n, b, epw, pos;
        logic [31:0] word, mask, d;
        logic [3:0]  strb;
        logic [7:0]  a;
        exp_addr.delete(); exp_data.delete(); exp_strb.delete();
        legal = 0;
        if (lm < 4 && sw < 3) legal = ((int'(v) % (1 << lm)) == 0);
        if (!legal) return;
        maxe = 8 * (1 << lm);
        n    = (l < maxe) ? l : maxe;
        b    = 1 << sw;
        epw  = 4 / b;
        mask = 32'((64'd1 << (8 * b)) - 64'd1);
        word = 0; strb = 0;
        for (int unsigned e = 0; e < n; e++) begin
            a = 8'(int'(v) * 8 + int'(e));
            exp_addr.push_back(a);
            d    = rdata_fn(a) & mask;
            pos  = (e % epw) * b;
            word = word | (d << (8 * pos));
            strb = strb | 4'(((1 << b) - 1) << pos);
            if ((e % epw) == epw - 1 || e == n - 1) begin
                exp_data.push_back(word);
                exp_strb.push_back(strb);
                word = 0; strb = 0;
            end
        end
    endtask

    // Register-file and consumer stand-ins: data appears exactly one cycle after rf_re
    always @(negedge clk) begin
        rf_re_s   = rf_re && nrst;
        rd_addr_s = rf_addr;
    end

    always @(posedge clk) begin
        #1;
        rf_rdata = rf_re_s ? rdata_fn(rd_addr_s) : $urandom;
        case (rdy_mode)
            0:       st_ready = 1'b1;
            1:       st_ready = 1'($urandom_range(0, 1));
            default: st_ready = 1'b0;
        endcase
    end

    // Compare process: every read and every accepted word against the model
    always @(negedge clk) begin
        if (!nrst) begin
            hold = 0;
        end else begin
            if (busy) busy_cnt++;
            if (err) err_cnt++;
            if (w_done) begin
                wd_cnt++;
                check("busy_low_with_w_done", busy, 0);
            end
            if (hold) begin
                check("stall_valid_held", st_valid, 1);
                check("stall_data_stable", st_data, hold_d);
                check("stall_strb_stable", st_strb, hold_s);
            end
            if (rf_re) begin
                re_cnt++;
                check("no_rf_re_with_st_valid", st_valid, 0);
                check("rf_re_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check("rf_addr", rf_addr, exp_addr.pop_front());
            end
            if (st_valid && st_ready) begin
                check("word_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) begin
                    check("st_data", st_data, exp_data.pop_front());
                    check("st_strb", st_strb, exp_strb.pop_front());
                end
            end
            hold   = st_valid && !st_ready;
            hold_d = st_data;
            hold_s = st_strb;
        end
    end

    task automatic start_txn(input logic [4:0] v, input logic [2:0] lm, input logic [2:0] sw,
                             input logic [31:0] l);
        @(posedge clk); #2;
        start = 1'b1; vs3 = v; lmul = lm; vsew = sw; vl = l;
        @(posedge clk); #2;
        start = 1'b0; vs3 = 5'($urandom); lmul = 3'($urandom); vsew = 3'($urandom); vl = $urandom;
    endtask

    task automatic wait_done(input int w0, input string tag);
        int g = 0;
        while (wd_cnt == w0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        check({tag, "_done_in_budget"}, g < 3000, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_rf_re"},    rf_re,    0);
        check({tag, "_rf_addr"},  rf_addr,  0);
        check({tag, "_st_valid"}, st_valid, 0);
        check({tag, "_st_data"},  st_data,  0);
        check({tag, "_st_strb"},  st_strb,  0);
        check({tag, "_w_done"},   w_done,   0);
        check({tag, "_err"},      err,      0);
    endtask

    int last_busy;

    task automatic do_txn(input logic [4:0] v, input logic [2:0] lm, input logic [2:0] sw,
                          input logic [31:0] l, input int mode, input int rdy, input string tag,
                          input bit prebuilt);
        bit legal;
        int b0, w0, e0, r0;
        if (!prebuilt) begin
            data_mode = mode;
            salt      = 8'($urandom);
        end
        build_model(v, lm, sw, l, legal);
        rdy_mode = rdy;
        b0 = busy_cnt; w0 = wd_cnt; e0 = err_cnt; r0 = re_cnt;
        start_txn(v, lm, sw, l);
        if (legal) wait_done(w0, tag);
        else repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check({tag, "_w_done_count"}, wd_cnt - w0, legal ? 1 : 0);
        check({tag, "_err_count"},    err_cnt - e0, legal ? 0 : 1);
        check({tag, "_reads_left"},   exp_addr.size(), 0);
        check({tag, "_words_left"},   exp_data.size(), 0);
        if (!legal) begin
            check({tag, "_no_rf_re"}, re_cnt - r0, 0);
            check({tag, "_no_busy"},  busy_cnt - b0, 0);
        end
        last_busy = busy_cnt - b0;
        rdy_mode = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        bit legal;
        int w0, r0, g;
        logic [4:0] v;
        logic [2:0] lm, sw;
        logic [31:0] l;

        nrst = 1'b0; start = 1'b0; vs3 = 0; lmul = 0; vsew = 0; vl = 0;
        st_ready = 1'b1; rf_rdata = 0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        #2 nrst = 1'b1;
        repeat (2) @(posedge clk);

        // SEW=32, one register: words 1..8, addresses 0x40..0x47, 3 cycles per word
        data_mode = 1;
        build_model(5'd8, 3'b000, 3'b010, 32'd8, legal);
        check("pin34_words", exp_data.size(), 8);
        check("pin34_addr_first", exp_addr[0], 8'h40);
        check("pin34_addr_last", exp_addr[7], 8'h47);
        check("pin34_word_first", exp_data[0], 32'd1);
        check("pin34_word_last", exp_data[7], 32'd8);
        check("pin34_strb", exp_strb[3], 4'hF);
        do_txn(5'd8, 3'b000, 3'b010, 32'd8, 1, 0, "t34", 1);
        check("t34_busy_cycles", last_busy, 24);

        // SEW=8, partial final word
        data_mode = 2;
        build_model(5'd0, 3'b000, 3'b000, 32'd6, legal);
        check("pin35_words", exp_data.size(), 2);
        check("pin35_word0", exp_data[0], 32'hA3A2A1A0);
        check("pin35_strb0", exp_strb[0], 4'hF);
        check("pin35_word1", exp_data[1], 32'h0000A5A4);
        check("pin35_strb1", exp_strb[1], 4'h3);
        do_txn(5'd0, 3'b000, 3'b000, 32'd6, 2, 0, "t35", 1);
        check("t35_busy_cycles", last_busy, 9 + 5);

        // LMUL=2 clamps vl=100 to 16 elements
        data_mode = 0; salt = 8'h5C;
        build_model(5'd16, 3'b001, 3'b010, 32'd100, legal);
        check("pin36_reads", exp_addr.size(), 16);
        check("pin36_addr_last", exp_addr[15], {5'd17, 3'd7});
        check("pin36_words", exp_data.size(), 16);
        do_txn(5'd16, 3'b001, 3'b010, 32'd100, 0, 0, "t36", 1);

        // Illegal requests
        do_txn(5'd9, 3'b001, 3'b010, 32'd8, 0, 0, "t37_misaligned", 0);
        do_txn(5'd0, 3'b000, 3'b011, 32'd8, 0, 0, "t37_bad_sew", 0);
        do_txn(5'd0, 3'b100, 3'b000, 32'd8, 0, 0, "t37_bad_lmul", 0);

        // vl=0 goes straight to completion
        do_txn(5'd4, 3'b000, 3'b001, 32'd0, 0, 0, "t_vl0", 0);
        check("t_vl0_busy_cycles", last_busy, 0);

        // Five-cycle stall on the first word
        data_mode = 0; salt = 8'($urandom);
        build_model(5'd3, 3'b000, 3'b001, 32'd5, legal);
        rdy_mode = 2;
        w0 = wd_cnt;
        start_txn(5'd3, 3'b000, 3'b001, 32'd5);
        g = 0;
        while (!st_valid && g < 50) begin @(negedge clk); g++; end
        check("t38_reached_out", st_valid, 1);
        r0 = re_cnt;
        repeat (5) @(negedge clk);
        check("t38_no_reads_while_stalled", re_cnt - r0, 0);
        check("t38_still_valid", st_valid, 1);
        rdy_mode = 0;
        wait_done(w0, "t38");
        @(negedge clk); #1;
        check("t38_w_done_count", wd_cnt - w0, 1);
        check("t38_words_left", exp_data.size(), 0);
        repeat (2) @(posedge clk);

        // Reset during the third element aborts the drain
        data_mode = 0; salt = 8'hC3;
        build_model(5'd0, 3'b000, 3'b000, 32'd8, legal);
        rdy_mode = 0;
        w0 = wd_cnt; r0 = re_cnt;
        start_txn(5'd0, 3'b000, 3'b000, 32'd8);
        g = 0;
        while ((re_cnt - r0) < 3 && g < 100) begin @(negedge clk); g++; end
        check("t39_third_read_seen", re_cnt - r0, 3);
        check("t39_partial_word_present", st_strb, 4'h3);
        #1 nrst = 1'b0;
        #1 check_idle_outputs("t39_in_reset");
        repeat (3) @(negedge clk);
        exp_addr.delete(); exp_data.delete(); exp_strb.delete();
        #3 nrst = 1'b1;
        repeat (4) @(negedge clk);
        check("t39_no_w_done", wd_cnt - w0, 0);
        do_txn(5'd2, 3'b000, 3'b000, 32'd7, 0, 1, "t39_after", 0);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            lm = 3'($urandom_range(0, 4));
            sw = 3'($urandom_range(0, 3));
            v  = 5'($urandom_range(0, 31));
            if (lm < 4 && $urandom_range(0, 3) != 0) v = (v >> lm) << lm;
            case ($urandom_range(0, 5))
                0:       l = 32'd0;
                1:       l = $urandom;
                default: l = $urandom_range(1, 70);
            endcase
            do_txn(v, lm, sw, l, 0, int'($urandom_range(0, 1)), "rand", 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
